diagram_memory_arbiter: RTL and testbench

- Shares one single-port diagram/logo byte memory between two clients.
- The video scan-out read path always has priority.
- Host writes (e.g. motor status glyph updates) go through a small FIFO. They are retired only while the memory is free during blanking.
- Sits between the diagram generator's logo fetch and the on-chip BSRAM.

---
 rtl/diagram_memory_arbiter.sv | 142 ++++++++++++++
 tb/tb_diagram_memory_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/diagram_memory_arbiter.sv
// Single-port diagram/logo memory arbiter: scan-out reads always win, host writes drain from a FIFO during blanking.
// Optional statistics outputs (stall_count, overflow_count) are enabled by defining DIAGRAM_ARB_STATS_EN.
module diagram_memory_arbiter #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  video_de,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fifo_empty
`ifdef DIAGRAM_ARB_STATS_EN
  ,
  output logic [15:0]           stall_count,
  output logic [15:0]           overflow_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {LOCKED, SETTLE, OPEN} state_t;

  state_t                state;
  logic [3:0]            settle_cnt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  push;
  logic                  pop;

  assign wr_ready   = (count != CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = wr_valid && wr_ready;
  // Permission uses the registered state, so the cycle video_de rises may still retire one write.
  assign pop        = !rd_req && (state == OPEN) && !fifo_empty;

  // Memory data is valid during the rd_valid cycle; hold the last captured word otherwise.
  assign rd_data = rd_valid ? mem_rdata : rd_data_q;

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= LOCKED;
      settle_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rd_valid   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      case (state)
        LOCKED: begin
          if (!video_de) begin
            if (SETTLE_CYCLES == 0) begin
              state <= OPEN;
            end else begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end
          end
        end
        SETTLE: begin
          if (video_de) begin
            state <= LOCKED;
          end else if (settle_cnt == 4'd0) begin
            state <= OPEN;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        OPEN: begin
          if (video_de) state <= LOCKED;
        end
        default: state <= LOCKED;
      endcase

      mem_en <= rd_req || pop;
      mem_we <= pop;
      if (rd_req) begin
        mem_addr <= rd_addr;
      end else if (pop) begin
        mem_addr  <= fifo_addr[rd_ptr];
        mem_wdata <= fifo_data[rd_ptr];
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      rd_valid <= mem_en && !mem_we;
      if (rd_valid) rd_data_q <= mem_rdata;
    end
  end

`ifdef DIAGRAM_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count    <= '0;
      overflow_count <= '0;
    end else begin
      if (!fifo_empty && ((state != OPEN) || rd_req) && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
      if (wr_valid && !wr_ready && (overflow_count != 16'hFFFF))
        overflow_count <= overflow_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_diagram_memory_arbiter.sv
// Directed bench for diagram_memory_arbiter with a 1-cycle registered memory model.
// Statistics checks are compiled in when DIAGRAM_ARB_STATS_EN is defined.
module tb_diagram_memory_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       video_de = 1'b1;
  logic       rd_req = 1'b0;
  logic [9:0] rd_addr = '0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [9:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       mem_en;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;
  logic       fifo_empty;
`ifdef DIAGRAM_ARB_STATS_EN
  logic [15:0] stall_count;
  logic [15:0] overflow_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  diagram_memory_arbiter dut (
    .clock(clock), .reset(reset), .video_de(video_de),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_empty(fifo_empty)
`ifdef DIAGRAM_ARB_STATS_EN
    , .stall_count(stall_count), .overflow_count(overflow_count)
`endif
  );

  always #5 clock = ~clock;

  // Memory model: synchronous single port, read data registered one cycle.
  logic [7:0] mem [1024];
  function automatic logic [7:0] iv(input logic [9:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction
  initial for (int i = 0; i < 1024; i++) mem[i] = iv(10'(i));
  always @(posedge clock) begin
    if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_mem(input string tag, input logic en, input logic we,
                         input logic [9:0] addr, input logic [7:0] wd);
    chk({tag, ".mem_en"}, 32'(mem_en), 32'(en));
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(we));
    if (en) chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
    if (en && we) chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(wd));
  endtask

  typedef struct packed {
    logic       vde;
    logic       wv;
    logic [9:0] waddr;
    logic [7:0] wdata;
    logic       e_ready;
    logic       e_empty;
    logic       e_en;
    logic       e_we;
    logic [9:0] e_addr;
    logic [7:0] e_wdata;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // Fill under active video, one refused push, then blanking releases writes after settling.
    tbl[0]  = '{1'b1, 1'b1, 10'h100, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 10'h101, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 10'h102, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 10'h103, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 10'h104, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00};
    tbl[6]  = '{1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00};
    tbl[8]  = '{1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 10'h100, 8'h11};
    tbl[9]  = '{1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 10'h101, 8'h22};
    tbl[10] = '{1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 10'h102, 8'h33};
    tbl[11] = '{1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 10'h103, 8'h44};
    tbl[12] = '{1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 10'h103, 8'h44};

    step(); step();
    chk("rst.mem_en", 32'(mem_en), 0);
    chk("rst.mem_we", 32'(mem_we), 0);
    chk("rst.mem_addr", 32'(mem_addr), 0);
    chk("rst.mem_wdata", 32'(mem_wdata), 0);
    chk("rst.rd_valid", 32'(rd_valid), 0);
    chk("rst.rd_data", 32'(rd_data), 0);
    chk("rst.wr_ready", 32'(wr_ready), 1);
    chk("rst.fifo_empty", 32'(fifo_empty), 1);
`ifdef DIAGRAM_ARB_STATS_EN
    chk("rst.stall_count", 32'(stall_count), 0);
    chk("rst.overflow_count", 32'(overflow_count), 0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      video_de = tbl[i].vde;
      wr_valid = tbl[i].wv;
      wr_addr  = tbl[i].waddr;
      wr_data  = tbl[i].wdata;
      step();
      chk($sformatf("tbl%0d.wr_ready", i), 32'(wr_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d.fifo_empty", i), 32'(fifo_empty), 32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d.mem_en", i), 32'(mem_en), 32'(tbl[i].e_en));
      chk($sformatf("tbl%0d.mem_we", i), 32'(mem_we), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d.mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d.mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].e_wdata));
    end

    // Settle sequence: video_de low at edge B; LOCKED->SETTLE->SETTLE->OPEN, write on the 4th edge.
    video_de = 1'b1; wr_valid = 1'b0;
    step();
    video_de = 1'b0; wr_valid = 1'b1; wr_addr = 10'h010; wr_data = 8'hAA;
    step(); chk_mem("settle.b", 0, 0, 0, 0);
    wr_addr = 10'h011; wr_data = 8'h55;
    step(); chk_mem("settle.c", 0, 0, 0, 0);
    wr_valid = 1'b0;
    step(); chk_mem("settle.d", 0, 0, 0, 0);
    step(); chk_mem("settle.w0", 1, 1, 10'h010, 8'hAA);
    step(); chk_mem("settle.w1", 1, 1, 10'h011, 8'h55);
    chk("settle.fifo_empty", 32'(fifo_empty), 1);
    step(); chk_mem("settle.idle", 0, 0, 0, 0);

    // Reads pre-empt pending writes; no bypass of a pending write to 0x030.
    rd_req = 1'b1; rd_addr = 10'h020; wr_valid = 1'b1; wr_addr = 10'h030; wr_data = 8'hC1;
    step(); chk_mem("rd.s1", 1, 0, 10'h020, 0);
    chk("rd.s1.rd_valid", 32'(rd_valid), 0);
    rd_addr = 10'h030; wr_addr = 10'h031; wr_data = 8'hC2;
    step(); chk_mem("rd.s2", 1, 0, 10'h030, 0);
    chk("rd.s2.rd_valid", 32'(rd_valid), 1);
    chk("rd.s2.rd_data", 32'(rd_data), 32'(iv(10'h020)));
    rd_addr = 10'h022; wr_valid = 1'b0;
    step(); chk_mem("rd.s3", 1, 0, 10'h022, 0);
    chk("rd.s3.rd_valid", 32'(rd_valid), 1);
    chk("rd.s3.rd_data", 32'(rd_data), 32'(iv(10'h030)));
    chk("rd.s3.fifo_empty", 32'(fifo_empty), 0);
    rd_req = 1'b0;
    step(); chk_mem("rd.s4", 1, 1, 10'h030, 8'hC1);
    chk("rd.s4.rd_valid", 32'(rd_valid), 1);
    chk("rd.s4.rd_data", 32'(rd_data), 32'(iv(10'h022)));
    step(); chk_mem("rd.s5", 1, 1, 10'h031, 8'hC2);
    chk("rd.s5.rd_valid", 32'(rd_valid), 0);
    chk("rd.s5.fifo_empty", 32'(fifo_empty), 1);
    step(); chk_mem("rd.s6", 0, 0, 0, 0);

    // Full FIFO: same-cycle pop does not let the push through.
    rd_req = 1'b1; rd_addr = 10'h040; wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 10'h200 + 10'(i); wr_data = 8'hD0 + 8'(i);
      step();
    end
    chk("full.wr_ready", 32'(wr_ready), 0);
    rd_req = 1'b0; wr_addr = 10'h2FF; wr_data = 8'hEE;
    step(); chk_mem("full.pop0", 1, 1, 10'h200, 8'hD0);
    chk("full.wr_ready_after", 32'(wr_ready), 1);
    wr_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step(); chk_mem($sformatf("full.pop%0d", i), 1, 1, 10'h200 + 10'(i), 8'hD0 + 8'(i));
      chk($sformatf("full.empty%0d", i), 32'(fifo_empty), (i == 3) ? 1 : 0);
    end
    step(); chk_mem("full.idle", 0, 0, 0, 0);

    // Reset with 3 pending writes while OPEN.
    rd_req = 1'b1; wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_addr = 10'h300 + 10'(i); wr_data = 8'h60 + 8'(i);
      step();
    end
    reset = 1'b1; rd_req = 1'b0; wr_valid = 1'b0;
    step(); chk_mem("rstop.r", 0, 0, 0, 0);
    chk("rstop.fifo_empty", 32'(fifo_empty), 1);
    chk("rstop.wr_ready", 32'(wr_ready), 1);
    reset = 1'b0; wr_valid = 1'b1; wr_addr = 10'h310; wr_data = 8'h77;
    step(); chk_mem("rstop.e1", 0, 0, 0, 0);
    wr_valid = 1'b0;
    step(); chk_mem("rstop.e2", 0, 0, 0, 0);
    step(); chk_mem("rstop.e3", 0, 0, 0, 0);
    step(); chk_mem("rstop.e4", 1, 1, 10'h310, 8'h77);

`ifdef DIAGRAM_ARB_STATS_EN
    reset = 1'b1; video_de = 1'b1;
    step();
    chk("stats.rst_stall", 32'(stall_count), 0);
    reset = 1'b0; wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 10'h380 + 10'(i); wr_data = 8'(i);
      step();
    end
    // Three stalled cycles accrue while filling (count 1..3), then ten while held full.
    for (int i = 0; i < 10; i++) step();
    chk("stats.overflow_count", 32'(overflow_count), 10);
    chk("stats.stall_count", 32'(stall_count), 13);
    chk("stats.mem_en", 32'(mem_en), 0);
    wr_valid = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
